// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Optional round-robin long-unit arbitration is selected with the WB_RR_EN macro.
package wb_port_arbiter_pkg;

  localparam int XLEN          = 32;
  localparam int NREGS         = 32;
  localparam int WB_STARVE_MAX = 8;

  typedef logic [4:0]      r_t;
  typedef logic [XLEN-1:0] data_t;

  localparam r_t ZERO = 5'd0;

  // Source that owns the write port in a given cycle.
  typedef enum logic [1:0] {
    NONE,
    PIPE,
    LD,
    MD
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy vector for destinations owned by in-flight long-latency ops,
// plus the decode-stage RAW/WAW hazard stall generated from it.
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic set_en,
  input  r_t   set_addr,
  input  logic clr_en,
  input  r_t   clr_addr,
  input  r_t   dec_rs1_addr,
  input  r_t   dec_rs2_addr,
  input  r_t   dec_rd_addr,
  input  logic dec_rs1_rden,
  input  logic dec_rs2_rden,
  input  logic dec_rd_wren,
  output logic dec_stall
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Clear is applied before set so a same-cycle set on the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign dec_stall = rst_n & ((dec_rs1_rden & busy[dec_rs1_addr]) |
                              (dec_rs2_rden & busy[dec_rs2_addr]) |
                              (dec_rd_wren  & busy[dec_rd_addr]));

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback,
// load return and mul/div; WB_RR_EN selects round-robin between the long units.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  pipe_wren,
  input  r_t    pipe_addr,
  input  data_t pipe_data,
  output logic  pipe_hold,
  input  logic  ld_valid,
  input  r_t    ld_addr,
  input  data_t ld_data,
  output logic  ld_ready,
  input  logic  md_valid,
  input  r_t    md_addr,
  input  data_t md_data,
  output logic  md_ready,
  input  logic  busy_set,
  input  r_t    busy_set_addr,
  input  r_t    dec_rs1_addr,
  input  r_t    dec_rs2_addr,
  input  r_t    dec_rd_addr,
  input  logic  dec_rs1_rden,
  input  logic  dec_rs2_rden,
  input  logic  dec_rd_wren,
  output logic  dec_stall,
  output logic  rd_wren,
  output r_t    rd_addr,
  output data_t rd_data
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Handshake: a long requester holds valid/addr/data stable until ready;
  // a transfer happens in every cycle with valid & ready. The pipeline has no
  // ready and is instead frozen by pipe_hold, re-presenting the same write.

  logic [3:0] starve_cnt;
  logic       hold_int;
  logic       pipe_eff;
  logic       ld_req;
  logic       md_req;
  logic       ld_zero;
  logic       md_zero;
  logic       ld_first;
  logic       long_gnt;
  wb_src_e    src;

  assign hold_int = (starve_cnt == STARVE_LIM);
  assign pipe_eff = pipe_wren & (pipe_addr != ZERO) & ~hold_int;
  assign ld_req   = ld_valid & (ld_addr != ZERO);
  assign md_req   = md_valid & (md_addr != ZERO);
  assign ld_zero  = ld_valid & (ld_addr == ZERO);
  assign md_zero  = md_valid & (md_addr == ZERO);

`ifdef WB_RR_EN
  logic rr_md;

  assign ld_first = ~rr_md;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rr_md <= 1'b0;
    else if (long_gnt) rr_md <= ~rr_md;
  end
`else
  assign ld_first = 1'b1;
`endif

  always_comb begin
    src = NONE;
    if (pipe_eff)                         src = PIPE;
    else if (ld_req && (ld_first || !md_req)) src = LD;
    else if (md_req)                      src = MD;
  end

  assign long_gnt  = (src == LD) || (src == MD);
  // x0 requests are acknowledged without touching the port.
  assign ld_ready  = rst_n & (ld_zero | (src == LD));
  assign md_ready  = rst_n & (md_zero | (src == MD));
  assign pipe_hold = rst_n & hold_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (long_gnt || !(ld_req || md_req)) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wren <= 1'b0;
      rd_addr <= ZERO;
      rd_data <= '0;
    end else begin
      rd_wren <= (src != NONE);
      case (src)
        PIPE: begin
          rd_addr <= pipe_addr;
          rd_data <= pipe_data;
        end
        LD: begin
          rd_addr <= ld_addr;
          rd_data <= ld_data;
        end
        MD: begin
          rd_addr <= md_addr;
          rd_data <= md_data;
        end
        default: begin
          rd_addr <= rd_addr;
          rd_data <= rd_data;
        end
      endcase
    end
  end

  wb_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en       (busy_set),
    .set_addr     (busy_set_addr),
    .clr_en       (long_gnt),
    .clr_addr     ((src == MD) ? md_addr : ld_addr),
    .dec_rs1_addr (dec_rs1_addr),
    .dec_rs2_addr (dec_rs2_addr),
    .dec_rd_addr  (dec_rd_addr),
    .dec_rs1_rden (dec_rs1_rden),
    .dec_rs2_rden (dec_rs2_rden),
    .dec_rd_wren  (dec_rd_wren),
    .dec_stall    (dec_stall)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the write-port rules.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int SMAX = WB_STARVE_MAX;
  localparam int EW   = 1 + 5 + XLEN;

  // ---------------- clock / reset / DUT ----------------
  logic  clk = 1'b0;
  logic  rst_n;
  logic  pipe_wren, ld_valid, md_valid, busy_set;
  r_t    pipe_addr, ld_addr, md_addr, busy_set_addr;
  data_t pipe_data, ld_data, md_data;
  r_t    dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic  dec_rs1_rden, dec_rs2_rden, dec_rd_wren;
  logic  pipe_hold, ld_ready, md_ready, dec_stall, rd_wren;
  r_t    rd_addr;
  data_t rd_data;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wren(pipe_wren), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_hold(pipe_hold),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .busy_set(busy_set), .busy_set_addr(busy_set_addr),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
    .dec_rs1_rden(dec_rs1_rden), .dec_rs2_rden(dec_rs2_rden), .dec_rd_wren(dec_rd_wren),
    .dec_stall(dec_stall),
    .rd_wren(rd_wren), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // ---------------- scoreboard and model state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  bit busy_m[32];
  int starve_m;
  int ptr_m;      // 0: load preferred, 1: mul/div preferred
  bit hold_m, ld_rdy_m, md_rdy_m, stall_m;
  logic got_hold, got_ldr, got_mdr, got_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    starve_m = 0;
    ptr_m    = 0;
    hold_m   = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    pipe_wren = 0; pipe_addr = 0; pipe_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    md_valid = 0; md_addr = 0; md_data = 0;
    busy_set = 0; busy_set_addr = 0;
    dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0;
    dec_rs1_rden = 0; dec_rs2_rden = 0; dec_rd_wren = 0;
  endtask

  // Called at a negedge with inputs applied; ends at the following negedge.
  task automatic tick();
    int win;  // 0 none, 1 pipe, 2 load, 3 mul/div
    bit pipe_win, ld_long, md_long;
    logic [EW-1:0] e;
    #1;
    hold_m   = (starve_m == SMAX);
    pipe_win = pipe_wren && (pipe_addr != 0) && !hold_m;
    ld_long  = ld_valid && (ld_addr != 0);
    md_long  = md_valid && (md_addr != 0);
    win = 0;
    if (pipe_win) win = 1;
    else if (ld_long && md_long) begin
`ifdef WB_RR_EN
      win = (ptr_m == 0) ? 2 : 3;
`else
      win = 2;
`endif
    end
    else if (ld_long) win = 2;
    else if (md_long) win = 3;
    ld_rdy_m = ld_valid && (ld_addr == 0 || win == 2);
    md_rdy_m = md_valid && (md_addr == 0 || win == 3);
    stall_m  = (dec_rs1_rden && busy_m[dec_rs1_addr]) ||
               (dec_rs2_rden && busy_m[dec_rs2_addr]) ||
               (dec_rd_wren  && busy_m[dec_rd_addr]);
    got_hold = pipe_hold; got_ldr = ld_ready; got_mdr = md_ready; got_stall = dec_stall;
    check("pipe_hold", 64'(got_hold), 64'(hold_m));
    check("ld_ready", 64'(got_ldr), 64'(ld_rdy_m));
    check("md_ready", 64'(got_mdr), 64'(md_rdy_m));
    check("dec_stall", 64'(got_stall), 64'(stall_m));
    case (win)
      1:       e = {1'b1, pipe_addr, pipe_data};
      2:       e = {1'b1, ld_addr, ld_data};
      3:       e = {1'b1, md_addr, md_data};
      default: e = '0;
    endcase
    exp_q.push_back(e);
    if (win == 2) busy_m[ld_addr] = 1'b0;
    if (win == 3) busy_m[md_addr] = 1'b0;
    if (busy_set && busy_set_addr != 0) busy_m[busy_set_addr] = 1'b1;
    if (win >= 2 || !(ld_long || md_long)) starve_m = 0;
    else if (starve_m < SMAX) starve_m++;
    if (win >= 2) ptr_m = 1 - ptr_m;
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("rd_wren", 64'(rd_wren), 64'(e[EW-1]));
    if (e[EW-1]) begin
      check("rd_addr", 64'(rd_addr), 64'(e[EW-2 -: 5]));
      check("rd_data", 64'(rd_data), 64'(e[XLEN-1:0]));
    end
  endtask

  // Requesters drop valid once the model says the transfer happened.
  task automatic retire();
    if (ld_valid && ld_rdy_m) ld_valid = 0;
    if (md_valid && md_rdy_m) md_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_ld_ready", 64'(ld_ready), 64'(0));
    check("rst_md_ready", 64'(md_ready), 64'(0));
    check("rst_pipe_hold", 64'(pipe_hold), 64'(0));
    check("rst_dec_stall", 64'(dec_stall), 64'(0));
    check("rst_rd_wren", 64'(rd_wren), 64'(0));
    check("rst_rd_addr", 64'(rd_addr), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    model_reset();
    idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic rand_step(input int pipe_pct);
    if (!ld_valid && $urandom_range(0, 2) == 0) begin
      ld_valid = 1; ld_addr = r_t'($urandom_range(0, 7)); ld_data = $urandom;
    end
    if (!md_valid && $urandom_range(0, 2) == 0) begin
      md_valid = 1; md_addr = r_t'($urandom_range(0, 7)); md_data = $urandom;
    end
    if (!hold_m) begin
      pipe_wren = ($urandom_range(0, 99) < pipe_pct);
      pipe_addr = r_t'($urandom_range(0, 7));
      pipe_data = $urandom;
    end
    busy_set      = ($urandom_range(0, 3) == 0);
    busy_set_addr = r_t'($urandom_range(0, 7));
    dec_rs1_addr  = r_t'($urandom_range(0, 7));
    dec_rs2_addr  = r_t'($urandom_range(0, 7));
    dec_rd_addr   = r_t'($urandom_range(0, 7));
    dec_rs1_rden  = 1'($urandom_range(0, 1));
    dec_rs2_rden  = 1'($urandom_range(0, 1));
    dec_rd_wren   = 1'($urandom_range(0, 1));
    tick();
    retire();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // Pipe write beats a pending load, load goes next cycle.
    pipe_wren = 1; pipe_addr = 5; pipe_data = 32'hA5;
    ld_valid = 1; ld_addr = 6; ld_data = 32'h66;
    tick();
    check("pipe_beats_ld", 64'(got_ldr), 64'(0));
    check("pipe_rd_addr", 64'(rd_addr), 64'(5));
    check("pipe_rd_data", 64'(rd_data), 64'(32'hA5));
    retire();
    pipe_wren = 0;
    tick();
    check("ld_after_pipe", 64'(got_ldr), 64'(1));
    retire();

    // Both long units contend; pointer now prefers mul/div in round-robin builds.
    ld_valid = 1; ld_addr = 7; ld_data = 32'h77;
    md_valid = 1; md_addr = 8; md_data = 32'h88;
    tick();
`ifdef WB_RR_EN
    check("rr_md_first", 64'(got_mdr), 64'(1));
    check("rr_ld_waits", 64'(got_ldr), 64'(0));
`else
    check("fixed_ld_first", 64'(got_ldr), 64'(1));
    check("fixed_md_waits", 64'(got_mdr), 64'(0));
`endif
    retire();
    tick();
    check("second_long_grant", 64'(got_ldr | got_mdr), 64'(1));
    retire();
    idle();

    // Scoreboard hazard and release on the md write.
    busy_set = 1; busy_set_addr = 9;
    tick();
    busy_set = 0; dec_rs1_addr = 9; dec_rs1_rden = 1;
    tick();
    check("stall_busy", 64'(got_stall), 64'(1));
    md_valid = 1; md_addr = 9; md_data = 32'h99;
    tick();
    check("stall_in_grant", 64'(got_stall), 64'(1));
    check("md9_rd_addr", 64'(rd_addr), 64'(9));
    retire();
    tick();
    check("stall_released", 64'(got_stall), 64'(0));

    // Same-cycle set and clear on register 9: set wins.
    busy_set = 1; busy_set_addr = 9;
    md_valid = 1; md_addr = 9; md_data = 32'h1234;
    tick();
    retire();
    busy_set = 0;
    tick();
    check("set_wins", 64'(got_stall), 64'(1));
    md_valid = 1; md_addr = 9; md_data = 32'h5678;
    tick();
    retire();
    idle();

    // Starvation: continuous pipe writes against a pending load.
    do_reset();
    ld_valid = 1; ld_addr = 3; ld_data = 32'h33;
    pipe_wren = 1;
    for (int i = 0; i < SMAX + 1; i++) begin
      if (!hold_m) pipe_addr = r_t'($urandom_range(1, 31));
      pipe_data = $urandom;
      tick();
      check("starve_hold", 64'(got_hold), 64'(i == SMAX));
      if (i == SMAX) check("starve_ld_grant", 64'(got_ldr), 64'(1));
      retire();
    end
    tick();
    check("hold_released", 64'(got_hold), 64'(0));
    idle();

    // x0 load acked alongside a real md write.
    ld_valid = 1; ld_addr = 0; ld_data = 32'hDEAD;
    md_valid = 1; md_addr = 4; md_data = 32'h44;
    tick();
    check("x0_ld_ready", 64'(got_ldr), 64'(1));
    check("x0_md_ready", 64'(got_mdr), 64'(1));
    check("x0_rd_wren", 64'(rd_wren), 64'(1));
    check("x0_rd_addr", 64'(rd_addr), 64'(4));
    retire();

    // Reset mid-stream with live requests and a busy register.
    pipe_wren = 1; pipe_addr = 2; pipe_data = 32'h22;
    busy_set = 1; busy_set_addr = 5;
    tick();
    busy_set = 0;
    ld_valid = 1; ld_addr = 0;
    md_valid = 1; md_addr = 6;
    do_reset();
    dec_rs1_addr = 5; dec_rs1_rden = 1;
    tick();
    check("busy_cleared", 64'(got_stall), 64'(0));
    idle();

    // Random traffic: moderate then heavy pipe load.
    repeat (300) rand_step(50);
    repeat (200) rand_step(90);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Owns the single register-file write port (rd_wren/rd_addr/rd_data) and shares it between three writers: the in-order pipeline writeback, the load-return path and the mul/div unit. It also keeps a busy scoreboard of destinations owned by in-flight long-latency ops and raises a decode stall on RAW/WAW hazards against them. It sits between the writeback stage, the long-latency units and the register file; its rd_* outputs drive the register file's write inputs directly.

## Interface
- STARVE_MAX, 8: consecutive denied cycles of a pending long request before the pipeline is frozen; legal range 1..15.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pipe_wren / pipe_addr / pipe_data  in  1 / r_t / data_t  pipeline writeback; carries no ready signal
- pipe_hold  out  1  freezes the writeback stage; the held instruction is re-presented
- ld_valid / ld_addr / ld_data  in  1 / r_t / data_t  load return; ld_ready  out  1
- md_valid / md_addr / md_data  in  1 / r_t / data_t  mul/div result; md_ready  out  1
- busy_set / busy_set_addr  in  1 / r_t  issue of a long op, marks its destination busy
- dec_rs1_addr, dec_rs2_addr, dec_rd_addr  in  r_t  decode-stage operands
- dec_rs1_rden, dec_rs2_rden, dec_rd_wren  in  1  decode-stage enables
- dec_stall  out  1  decode hazard against a busy register
- rd_wren / rd_addr / rd_data  out  1 / r_t / data_t  registered write port to the register file

## Operation
- Pipe write is effective when pipe_wren=1, pipe_addr≠0 and pipe_hold=0. An effective pipe write always wins the port.
- Long grant: a long request is granted only when no effective pipe write exists in the same cycle. The winner is chosen by the WB_RR_EN policy. The grant sets the matching ready combinationally in the same cycle.
- A long request addressed to x0 is acked (ready=1) in the same cycle without using the port. It never blocks the other requester, and rd_wren stays 0 for it.
- A pipe write to x0 is dropped and leaves the port free.
- Scoreboard busy[31:0]:
  - busy_set with addr≠0 sets the bit.
  - A granted long write clears the bit for its address.
  - If set and clear hit the same address in one cycle, set wins.
  - busy[0] is always 0.
- dec_stall = (rs1_rden & busy[rs1]) | (rs2_rden & busy[rs2]) | (rd_wren & busy[rd]). It is combinational from registered busy.
- Starvation counter (4 bits):
  - Increments each cycle a long request with addr≠0 is valid but not granted; saturates at STARVE_MAX.
  - Clears on any long grant, or when no long request is valid.
- pipe_hold = (counter == STARVE_MAX), combinational from the counter.

## Timing
- Ready is combinational in the request cycle. rd_wren/rd_addr/rd_data update at the next posedge, so write latency is 1 cycle. The register file commits at the following negedge, and its bypass covers same-cycle reads.
- The busy clear takes effect at the same posedge as the rd_* update, so a stalled reader is released exactly when the data appears on the bypass.
- Requesters hold valid/addr/data stable until ready. A transfer happens in any cycle with valid & ready.
- With counter at STARVE_MAX, pipe_hold=1 and the long request is granted in that cycle. The counter clears at the next posedge.
- Reset values: rd_wren=0, rd_addr=0, rd_data=0, busy=0, counter=0, RR pointer=load.
- While rst_n=0: ld_ready=0, md_ready=0, pipe_hold=0, dec_stall=0.
- Reset asserted mid-operation discards any pending grant and scoreboard state immediately.

## Configuration
- WB_RR_EN defined: round-robin arbitration between load and mul/div. A 1-bit pointer selects the preferred unit and flips to the other unit after each granted long write to a non-x0 address.
- WB_RR_EN undefined: fixed priority, load before mul/div. The pointer register is not built.

## Structure
- Add to the package defines:
  - wb_src_e (NONE, PIPE, LD, MD)
  - the STARVE_MAX default as constant WB_STARVE_MAX
- The r_t/data_t/XLEN types and the ZERO register index come from defines.
- One sub-module: wb_scoreboard, holding the busy vector, the set/clear logic and the dec_stall generation.
- The arbiter, starvation counter and output register live in the top module.

## Test plan
- pipe_wren=1 addr=5 data=0xA5 -> rd_wren=1 rd_addr=5 rd_data=0xA5 one cycle later; ld_valid (addr=6) held with ld_ready=0 that cycle.
- ld_valid and md_valid both set, addr 7/8, no pipe write -> without WB_RR_EN: ld first, md next cycle; with WB_RR_EN and pointer=md: md first.
- busy_set addr=9, then dec_rs1_addr=9 rden=1 -> dec_stall=1 until md write to 9 is granted; dec_stall=0 in the cycle rd_addr=9 appears.
- busy_set and md grant both to addr=9 in the same cycle -> busy[9] stays 1.
- pipe_wren=1 (addr≠0) every cycle with ld_valid addr=3 pending -> pipe_hold=1 on the 9th cycle (STARVE_MAX=8), ld granted that cycle, pipe_hold=0 afterwards.
- ld_valid addr=0 concurrent with md_valid addr=4 -> ld_ready=1 and md_ready=1 in the same cycle; only addr 4 is written; rst_n pulsed mid-stream clears busy and rd_wren.
